// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// jk_bank_pkg : shared FSM state type and J/K excitation codes  (rev 1.0)
// ============================================================================
package jk_bank_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_VERIFY = 2'd3
  } jkb_state_t;

  // {J,K} codes for one flop lane
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/jk_excite_lane.sv
`default_nettype none
// ============================================================================
// jk_excite_lane : per-lane J/K code from current state q and target t (rev 1.0)
// ============================================================================
module jk_excite_lane
  import jk_bank_pkg::*;
(
  input  logic       q,
  input  logic       t,
  input  logic       toggle_pref,
  output logic [1:0] code
);

  always_comb begin
    code = JK_HOLD;
    if (q != t) begin
      if (toggle_pref) code = JK_TGL;
      else if (t)      code = JK_SET;
      else             code = JK_RST;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// jk_bank_driver : drives a JK flop bank to a target with settle/verify/retry
// rev 1.0
// ============================================================================
module jk_bank_driver
  import jk_bank_pkg::*;
#(
  parameter int WD          = 8,
  parameter int SETTLE      = 1,
  parameter int MAX_RETRY   = 2,
  parameter int TOGGLE_PREF = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WD-1:0]   in_target,
  input  logic            in_clear,
  input  logic [WD-1:0]   q_in,
  output logic [2*WD-1:0] jk_out,
  output logic            flop_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  jkb_state_t      r_state, w_state_nxt;
  logic [WD-1:0]   r_target, w_target_nxt;
  logic            r_clear, w_clear_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic [CW-1:0]   r_settle, w_settle_nxt;
  logic [2*WD-1:0] w_jk_nxt;
  logic            w_rst_nxt, w_done_nxt, w_err_nxt;
  logic            w_drive;
  logic [WD-1:0]   w_lane_tgt;
  logic            w_clr_src;
  logic [2*WD-1:0] w_code;

  // On accept the target is not latched yet, so the encoder sees the request directly
  assign w_lane_tgt = (r_state == S_IDLE) ? (in_clear ? '0 : in_target) : r_target;
  assign w_clr_src  = (r_state == S_IDLE) ? in_clear : r_clear;

  generate
    for (genvar i = 0; i < WD; i++) begin : g_lane
      jk_excite_lane u_lane (
        .q           (q_in[i]),
        .t           (w_lane_tgt[i]),
        .toggle_pref (TOGGLE_PREF != 0),
        .code        (w_code[2*i+1:2*i])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_clear_nxt  = r_clear;
    w_retry_nxt  = r_retry;
    w_settle_nxt = r_settle;
    w_jk_nxt     = '0;
    w_rst_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_drive      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_target_nxt = w_lane_tgt;
          w_clear_nxt  = in_clear;
          w_retry_nxt  = '0;
          w_state_nxt  = S_DRIVE;
          w_drive      = 1'b1;
        end
      end
      S_DRIVE: begin
        w_settle_nxt = CW'(SETTLE - 1);
        w_state_nxt  = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == '0) w_state_nxt = S_VERIFY;
        else                w_settle_nxt = r_settle - 1'b1;
      end
      S_VERIFY: begin
        if (q_in == r_target) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_retry < RW'(MAX_RETRY)) begin
          w_retry_nxt = r_retry + 1'b1;
          w_state_nxt = S_DRIVE;
          w_drive     = 1'b1;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_drive) begin
      if (w_clr_src) w_rst_nxt = 1'b1;
      else           w_jk_nxt  = w_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_clear  <= 1'b0;
      r_retry  <= '0;
      r_settle <= '0;
      jk_out   <= '0;
      flop_rst <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_clear  <= w_clear_nxt;
      r_retry  <= w_retry_nxt;
      r_settle <= w_settle_nxt;
      jk_out   <= w_jk_nxt;
      flop_rst <= w_rst_nxt;
      done     <= w_done_nxt;
      err      <= w_err_nxt;
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ============================================================================
// tb_jk_bank_driver : directed vectors against two drivers (set/reset, toggle)
// ============================================================================
module tb_jk_bank_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_clear = 1'b0;
  logic [7:0]  in_target = 8'h00;
  logic [7:0]  bank0, bank1, q0, q1;
  logic [7:0]  stuck = 8'h00;
  logic        preset_en = 1'b0;
  logic [7:0]  preset_val = 8'h00;
  logic        rdy0, rdy1, frst0, frst1, busy0, busy1, done0, done1, err0, err1;
  logic [15:0] jk0, jk1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign q0 = bank0 & ~stuck;
  assign q1 = bank1;

  jk_bank_driver #(.WD(8), .SETTLE(1), .MAX_RETRY(2), .TOGGLE_PREF(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_target(in_target), .in_clear(in_clear), .q_in(q0), .jk_out(jk0),
    .flop_rst(frst0), .busy(busy0), .done(done0), .err(err0));

  jk_bank_driver #(.WD(8), .SETTLE(1), .MAX_RETRY(2), .TOGGLE_PREF(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_target(in_target), .in_clear(in_clear), .q_in(q1), .jk_out(jk1),
    .flop_rst(frst1), .busy(busy1), .done(done1), .err(err1));

  function automatic logic [7:0] jk_step(input logic [7:0] b, input logic [15:0] jk, input logic r);
    logic [7:0] n;
    n = b;
    if (r) return 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (jk[2*i +: 2])
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        2'b11:   n[i] = ~b[i];
        default: n[i] = b[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (preset_en) begin
      bank0 <= preset_val;
      bank1 <= preset_val;
    end else begin
      bank0 <= jk_step(bank0, jk0, frst0);
      bank1 <= jk_step(bank1, jk1, frst1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preset(input logic [7:0] v);
    @(negedge clk);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  typedef struct {
    bit          sel;
    logic [7:0]  bank;
    logic [7:0]  tgt;
    bit          clr;
    logic [7:0]  stk;
    logic [15:0] exp_jk;
    int          exp_rst;
    int          exp_drv;
    int          exp_done;
    int          exp_err;
    logic [7:0]  exp_q;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int done_c, err_c, drv, rstc, both;
    logic [15:0] jk;
    logic fr, dn, er, rd, bz;
    logic [7:0] q;
    stuck = v.stk;
    preset(v.bank);
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = v.tgt;
    in_clear  = v.clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_clear = 1'b0;
    done_c = 0; err_c = 0; drv = 0; rstc = 0; both = 0;
    rd = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      jk = v.sel ? jk1 : jk0;
      fr = v.sel ? frst1 : frst0;
      dn = v.sel ? done1 : done0;
      er = v.sel ? err1 : err0;
      bz = v.sel ? busy1 : busy0;
      rd = v.sel ? rdy1 : rdy0;
      if (c == 1) begin
        check($sformatf("%s.jk_c1", tag), 32'(jk), 32'(v.exp_jk));
        check($sformatf("%s.busy_c1", tag), 32'(bz), 32'd1);
      end
      if (jk != 16'h0 || fr) drv++;
      if (fr) rstc++;
      if (dn && er) both++;
      if (dn && done_c == 0) done_c = c;
      if (er && err_c == 0) err_c = c;
      if (done_c != 0 || err_c != 0) break;
    end
    q = v.sel ? q1 : q0;
    check($sformatf("%s.done_cycle", tag), 32'(done_c), 32'(v.exp_done));
    check($sformatf("%s.err_cycle", tag), 32'(err_c), 32'(v.exp_err));
    check($sformatf("%s.drive_cycles", tag), 32'(drv), 32'(v.exp_drv));
    check($sformatf("%s.rst_cycles", tag), 32'(rstc), 32'(v.exp_rst));
    check($sformatf("%s.bank", tag), 32'(q), 32'(v.exp_q));
    check($sformatf("%s.ready_end", tag), 32'(rd), 32'd1);
    check($sformatf("%s.done_and_err", tag), 32'(both), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int de;
    vecs[0] = '{1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 16'h8822, 0, 1, 4, 0,  8'hA5};
    vecs[1] = '{1'b1, 8'hFF, 8'h0F, 1'b0, 8'h00, 16'hFF00, 0, 1, 4, 0,  8'h0F};
    vecs[2] = '{1'b0, 8'h3C, 8'h3C, 1'b0, 8'h00, 16'h0000, 0, 0, 4, 0,  8'h3C};
    vecs[3] = '{1'b0, 8'h00, 8'h08, 1'b0, 8'h08, 16'h0080, 0, 3, 0, 10, 8'h00};
    vecs[4] = '{1'b0, 8'h5A, 8'h00, 1'b1, 8'h00, 16'h0000, 1, 1, 4, 0,  8'h00};
    vecs[5] = '{1'b1, 8'h00, 8'h81, 1'b0, 8'h00, 16'hC003, 0, 1, 4, 0,  8'h81};

    #2 reset = 1'b0;
    #1;
    check("rst.ready", 32'(rdy0), 32'd1);
    check("rst.jk", 32'(jk0), 32'd0);
    check("rst.outs", 32'({frst0, busy0, done0, err0}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort during SETTLE
    stuck = 8'h00;
    preset(8'h00);
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = 8'hFF;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort.jk", 32'(jk0), 32'd0);
    check("abort.outs", 32'({frst0, busy0, done0, err0}), 32'd0);
    check("abort.ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    de = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0 || err0) de++;
    end
    check("abort.no_pulse", 32'(de), 32'd0);
    run_vec('{1'b0, 8'hFF, 8'h12, 1'b0, 8'h00, 16'h5451, 0, 1, 4, 0, 8'h12}, "after_abort");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
